// File: rtl/bp_sacc_dma_engine.sv
// rtl/bp_sacc_dma_engine.sv - multi-channel pipelined DMA fetch engine feeding accelerator scratchpads
module bp_sacc_dma_engine #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64,
  parameter int num_chan_p    = 3,
  parameter int spm_els_p     = 4096,
  parameter int max_out_p     = 4,
  localparam int chan_w_lp    = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  localparam int spm_aw_lp    = (spm_els_p > 1) ? $clog2(spm_els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     csr_v_i,
  input  logic                     csr_w_i,
  input  logic [2:0]               csr_addr_i,
  input  logic [63:0]              csr_data_i,
  output logic                     csr_v_o,
  output logic [63:0]              csr_data_o,
  output logic                     mem_cmd_v_o,
  output logic [paddr_width_p-1:0] mem_cmd_addr_o,
  input  logic                     mem_cmd_ready_i,
  input  logic                     mem_resp_v_i,
  input  logic [data_width_p-1:0]  mem_resp_data_i,
  output logic                     spm_w_v_o,
  output logic [chan_w_lp-1:0]     spm_chan_o,
  output logic [spm_aw_lp-1:0]     spm_addr_o,
  output logic [data_width_p-1:0]  spm_data_o,
  output logic                     busy_o,
  output logic                     done_irq_o
);

  // Counters must hold the full transfer length, which can equal spm_els_p.
  localparam int cnt_w_lp = $clog2(spm_els_p + 1);
  localparam int out_w_lp = $clog2(max_out_p + 1);
  localparam logic [out_w_lp-1:0]      max_out_lp = out_w_lp'(max_out_p);
  localparam logic [paddr_width_p-1:0] stride_lp  = paddr_width_p'(data_width_p / 8);
  localparam logic [63:0]              els_lp     = 64'(spm_els_p);
  localparam logic [63:0]              nchan_lp   = 64'(num_chan_p);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [63:0]              base_q, base_d, len_q, len_d, chan_q, chan_d;
  logic [paddr_width_p-1:0] addr_q, addr_d;
  logic [cnt_w_lp-1:0]      issued_q, issued_d, received_q, received_d;
  logic [out_w_lp-1:0]      out_q, out_d;
  logic                     done_q, done_d, err_q, err_d;
  logic                     csr_v_q;
  logic [63:0]              csr_data_q, csr_data_d;

  logic        busy, active, cmd_fire, resp_fire, csr_wr, start, cfg_bad;
  logic [63:0] issued_ext, received_ext, rd_data;

  assign busy         = (state_q != S_IDLE);
  assign active       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign issued_ext   = 64'(issued_q);
  assign received_ext = 64'(received_q);

  // Request valid depends only on counters that move on handshake, so it never retracts.
  assign mem_cmd_v_o    = (state_q == S_ISSUE) && (issued_ext < len_q) && (out_q < max_out_lp);
  assign mem_cmd_addr_o = addr_q;
  assign cmd_fire       = mem_cmd_v_o && mem_cmd_ready_i;
  assign resp_fire      = mem_resp_v_i && active;

  assign spm_w_v_o  = resp_fire;
  assign spm_chan_o = chan_q[chan_w_lp-1:0];
  assign spm_addr_o = received_q[spm_aw_lp-1:0];
  assign spm_data_o = mem_resp_data_i;
  assign busy_o     = busy;
  assign done_irq_o = (state_q == S_DONE);
  assign csr_v_o    = csr_v_q;
  assign csr_data_o = csr_data_q;

  assign csr_wr  = csr_v_i && csr_w_i;
  assign start   = csr_wr && (csr_addr_i == 3'd3) && !busy;
  assign cfg_bad = (len_q > els_lp) || (chan_q >= nchan_lp);

  // CSR read mux; status is taken from the cycle the read is presented.
  always_comb begin
    rd_data = '0;
    case (csr_addr_i)
      3'd0:    rd_data = base_q;
      3'd1:    rd_data = len_q;
      3'd2:    rd_data = chan_q;
      3'd4:    rd_data = {61'b0, err_q, busy, done_q};
      default: rd_data = '0;
    endcase
    csr_data_d = (csr_v_i && !csr_w_i) ? rd_data : '0;
  end

  // Next-state: CSR writes first, then counters, then FSM so entering DONE wins over a clear.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    chan_d     = chan_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    received_d = received_q;
    out_d      = out_q;
    done_d     = done_q;
    err_d      = err_q;

    if (csr_wr) begin
      if ((csr_addr_i <= 3'd3) && busy) begin
        err_d = 1'b1;
      end else begin
        case (csr_addr_i)
          3'd0:    base_d = csr_data_i;
          3'd1:    len_d  = csr_data_i;
          3'd2:    chan_d = csr_data_i;
          3'd5: begin
            done_d = 1'b0;
            err_d  = 1'b0;
          end
          default: ;
        endcase
      end
    end

    if (cmd_fire) begin
      issued_d = issued_q + 1'b1;
      addr_d   = addr_q + stride_lp;
    end
    if (resp_fire) received_d = received_q + 1'b1;
    case ({cmd_fire, resp_fire})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b0;
          if (cfg_bad) begin
            err_d = 1'b1;
          end else if (len_q == 64'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            issued_d   = '0;
            received_d = '0;
            out_d      = '0;
            addr_d     = base_q[paddr_width_p-1:0];
          end
        end
      end
      S_ISSUE: if (issued_ext == len_q) state_d = S_DRAIN;
      S_DRAIN: begin
        if (received_ext == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and CSR registers; reset aborts any transfer without signalling completion.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      chan_q     <= '0;
      addr_q     <= '0;
      issued_q   <= '0;
      received_q <= '0;
      out_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      csr_v_q    <= 1'b0;
      csr_data_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      chan_q     <= chan_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      out_q      <= out_d;
      done_q     <= done_d;
      err_q      <= err_d;
      csr_v_q    <= csr_v_i;
      csr_data_q <= csr_data_d;
    end
  end

endmodule

// File: tb/tb_bp_sacc_dma_engine.sv
// tb/tb_bp_sacc_dma_engine.sv - randomized self-checking bench for bp_sacc_dma_engine
module tb_bp_sacc_dma_engine;
  localparam int PA  = 40;
  localparam int DW  = 64;
  localparam int NCH = 3;
  localparam int ELS = 4096;
  localparam int MO  = 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          csr_v_i, csr_w_i;
  logic [2:0]    csr_addr_i;
  logic [63:0]   csr_data_i;
  logic          csr_v_o;
  logic [63:0]   csr_data_o;
  logic          mem_cmd_v_o;
  logic [PA-1:0] mem_cmd_addr_o;
  logic          mem_cmd_ready_i;
  logic          mem_resp_v_i;
  logic [DW-1:0] mem_resp_data_i;
  logic          spm_w_v_o;
  logic [1:0]    spm_chan_o;
  logic [11:0]   spm_addr_o;
  logic [DW-1:0] spm_data_o;
  logic          busy_o, done_irq_o;

  bp_sacc_dma_engine #(
    .paddr_width_p(PA), .data_width_p(DW), .num_chan_p(NCH), .spm_els_p(ELS), .max_out_p(MO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .csr_v_i(csr_v_i), .csr_w_i(csr_w_i), .csr_addr_i(csr_addr_i), .csr_data_i(csr_data_i),
    .csr_v_o(csr_v_o), .csr_data_o(csr_data_o),
    .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i),
    .spm_w_v_o(spm_w_v_o), .spm_chan_o(spm_chan_o), .spm_addr_o(spm_addr_o), .spm_data_o(spm_data_o),
    .busy_o(busy_o), .done_irq_o(done_irq_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;

  // Reference model of the current transfer: the k-th request must target base+8k and
  // the k-th scratchpad write must land at index k of the chosen channel with mem_f(base+8k).
  logic [63:0] exp_base = '0;
  int          exp_len = 0;
  int          exp_chan = 0;
  int          n_cmd = 0, n_spm = 0, outst = 0, irq_cnt = 0, irq_mark = 0;
  logic [39:0] first_addr = '0, last_addr = '0;
  logic [63:0] pend_data[$];
  int unsigned pend_due[$];
  int unsigned last_due = 0;
  int          ready_mode = 0;
  bit          resp_en = 1'b1;
  int          lat_lo = 3, lat_hi = 3;

  function automatic logic [63:0] mem_f(input logic [39:0] a);
    return {a, 24'hC35A96} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [39:0] exp_addr(input int n);
    logic [39:0] b;
    b = exp_base[39:0];
    return b + 40'(n * 8);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory side: ready pattern plus in-order responses after a per-request latency.
  initial begin
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i    = 1'b0;
    mem_resp_data_i = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (ready_mode)
        0:       mem_cmd_ready_i = 1'b1;
        1:       mem_cmd_ready_i = ~mem_cmd_ready_i;
        default: mem_cmd_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (resp_en && pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_resp_v_i    = 1'b1;
        mem_resp_data_i = pend_data.pop_front();
        void'(pend_due.pop_front());
      end else begin
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = '0;
      end
    end
  end

  // Compare process: checks every cycle's outputs against the transfer model.
  initial begin
    bit          prev_stall;
    logic [39:0] prev_addr;
    int unsigned due;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("cmd_hold_v", mem_cmd_v_o, 1);
          chk("cmd_hold_addr", mem_cmd_addr_o, prev_addr);
        end
        prev_stall = mem_cmd_v_o && !mem_cmd_ready_i;
        prev_addr  = mem_cmd_addr_o;
        if (mem_cmd_v_o && mem_cmd_ready_i) begin
          chk("cmd_count", n_cmd < exp_len, 1);
          chk("cmd_addr", mem_cmd_addr_o, exp_addr(n_cmd));
          chk("cmd_cap", outst < MO, 1);
          if (n_cmd == 0) first_addr = mem_cmd_addr_o;
          last_addr = mem_cmd_addr_o;
          due = cyc + $urandom_range(lat_lo, lat_hi);
          if (due < last_due) due = last_due;
          last_due = due;
          pend_data.push_back(mem_f(mem_cmd_addr_o));
          pend_due.push_back(due);
          n_cmd++;
          outst++;
        end
        if (spm_w_v_o) begin
          chk("spm_count", n_spm < exp_len, 1);
          chk("spm_chan", spm_chan_o, 64'(exp_chan));
          chk("spm_addr", spm_addr_o, 64'(n_spm));
          chk("spm_data", spm_data_o, mem_f(exp_addr(n_spm)));
          n_spm++;
        end
        if (mem_resp_v_i && outst > 0) outst--;
        if (done_irq_o) begin
          irq_cnt++;
          chk("irq_after_data", n_spm, exp_len);
        end
      end
    end
  end

  task automatic csr_write(input logic [2:0] a, input logic [63:0] d);
    @(posedge clk);
    #1;
    csr_v_i = 1'b1; csr_w_i = 1'b1; csr_addr_i = a; csr_data_i = d;
    @(posedge clk);
    #1;
    csr_v_i = 1'b0; csr_w_i = 1'b0;
    @(negedge clk);
    chk("csr_wr_ack", csr_v_o, 1);
    chk("csr_wr_data", csr_data_o, 0);
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [63:0] d);
    @(posedge clk);
    #1;
    csr_v_i = 1'b1; csr_w_i = 1'b0; csr_addr_i = a; csr_data_i = '0;
    @(posedge clk);
    #1;
    csr_v_i = 1'b0;
    @(negedge clk);
    chk("csr_rd_ack", csr_v_o, 1);
    d = csr_data_o;
  endtask

  task automatic run_xfer(input logic [63:0] b, input int len, input int ch);
    csr_write(3'd0, b);
    csr_write(3'd1, 64'(len));
    csr_write(3'd2, 64'(ch));
    exp_base = b; exp_len = len; exp_chan = ch;
    n_cmd = 0; n_spm = 0; irq_mark = irq_cnt;
    csr_write(3'd3, 64'd0);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (i < budget) begin
      @(negedge clk);
      if (!busy_o) break;
      i++;
    end
    chk("wait_idle_timeout", busy_o, 0);
  endtask

  task automatic check_xfer(input string tag, input int len);
    chk({tag, "_cmds"}, n_cmd, len);
    chk({tag, "_words"}, n_spm, len);
    chk({tag, "_irq"}, irq_cnt - irq_mark, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    reset_i = 1'b1;
    csr_v_i = 1'b0; csr_w_i = 1'b0; csr_addr_i = '0; csr_data_i = '0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_cmd_v", mem_cmd_v_o, 0);
    chk("rst_spm_v", spm_w_v_o, 0);
    chk("rst_irq", done_irq_o, 0);
    chk("rst_csr_v", csr_v_o, 0);
    csr_read(3'd4, d); chk("rst_status", d, 0);
    csr_read(3'd0, d); chk("rst_base", d, 0);
    csr_read(3'd1, d); chk("rst_len", d, 0);

    // Basic 8-word fetch into channel 1 with 3-cycle memory latency.
    run_xfer(64'h8000_0000, 8, 1);
    wait_idle(300);
    check_xfer("basic", 8);
    chk("basic_first_addr", first_addr, 40'h00_8000_0000);
    chk("basic_last_addr", last_addr, 40'h00_8000_0038);
    csr_read(3'd4, d); chk("basic_status", d, 64'h1);
    csr_read(3'd0, d); chk("basic_base_rb", d, 64'h8000_0000);

    // Responses withheld: only max_out_p requests may be accepted.
    resp_en = 1'b0;
    run_xfer(64'h1000, 10, 2);
    repeat (20) @(negedge clk);
    chk("withheld_cmds", n_cmd, 4);
    chk("withheld_busy", busy_o, 1);
    resp_en = 1'b1;
    wait_idle(300);
    check_xfer("withheld", 10);

    // Ready toggling every cycle with variable latency.
    ready_mode = 1; lat_lo = 1; lat_hi = 4;
    run_xfer(64'h2_0000_0040, 16, 0);
    wait_idle(500);
    check_xfer("toggle", 16);
    ready_mode = 0; lat_lo = 3; lat_hi = 3;

    // Address wrap at the top of the physical address space.
    run_xfer(64'hFF_FFFF_FFF0, 4, 2);
    wait_idle(200);
    check_xfer("wrap", 4);
    chk("wrap_last_addr", last_addr, 40'h8);

    // Zero-length start completes with no requests.
    csr_write(3'd1, 64'd0);
    exp_len = 0; n_cmd = 0; n_spm = 0; irq_mark = irq_cnt;
    csr_write(3'd3, 64'd0);
    chk("len0_irq_on", done_irq_o, 1);
    @(negedge clk);
    chk("len0_irq_off", done_irq_o, 0);
    chk("len0_busy", busy_o, 0);
    csr_read(3'd4, d); chk("len0_status", d, 64'h1);
    chk("len0_cmds", n_cmd, 0);
    chk("len0_irq_count", irq_cnt - irq_mark, 1);

    // Illegal length and channel raise err and never start.
    csr_write(3'd5, 64'd0);
    csr_read(3'd4, d); chk("clear_status", d, 0);
    csr_write(3'd1, 64'(ELS + 1));
    csr_write(3'd2, 64'd0);
    exp_len = 0; n_cmd = 0; n_spm = 0;
    csr_write(3'd3, 64'd0);
    csr_read(3'd4, d); chk("badlen_status", d, 64'h4);
    csr_write(3'd5, 64'd0);
    csr_write(3'd1, 64'd4);
    csr_write(3'd2, 64'(NCH));
    csr_write(3'd3, 64'd0);
    csr_read(3'd4, d); chk("badchan_status", d, 64'h4);
    chk("badchan_cmds", n_cmd, 0);
    csr_write(3'd5, 64'd0);

    // Base write while busy is ignored but flagged.
    run_xfer(64'h3000, 12, 0);
    csr_write(3'd0, 64'hDEAD_0000);
    wait_idle(300);
    check_xfer("busywr", 12);
    csr_read(3'd4, d); chk("busywr_status", d, 64'h5);
    csr_read(3'd0, d); chk("busywr_base", d, 64'h3000);
    csr_write(3'd5, 64'd0);

    // Maximum legal length.
    lat_lo = 1; lat_hi = 1;
    run_xfer(64'h4000_0000, ELS, 2);
    wait_idle(ELS * 3);
    check_xfer("maxlen", ELS);

    // Randomized transfers with random ready and latency.
    ready_mode = 2;
    for (int t = 0; t < 6; t++) begin
      logic [63:0] b;
      int          l, c;
      b = {$urandom, $urandom};
      l = int'($urandom_range(1, 24));
      c = int'($urandom_range(0, NCH - 1));
      lat_lo = 1; lat_hi = int'($urandom_range(1, 6));
      run_xfer(b, l, c);
      wait_idle(600);
      check_xfer("rand", l);
    end
    ready_mode = 0; lat_lo = 3; lat_hi = 3;

    // Reset mid-transfer: late responses must be dropped, no completion.
    run_xfer(64'h5000, 16, 1);
    begin
      int i;
      i = 0;
      while (n_spm < 3 && i < 100) begin
        @(negedge clk);
        i++;
      end
    end
    chk("midrst_reached_word3", n_spm >= 3, 1);
    @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    exp_len = 0; n_cmd = 0; n_spm = 0; outst = 0; irq_mark = irq_cnt;
    repeat (20) @(negedge clk);
    chk("midrst_late_resps_sent", pend_data.size(), 0);
    chk("midrst_irq", irq_cnt - irq_mark, 0);
    chk("midrst_busy", busy_o, 0);
    csr_read(3'd4, d); chk("midrst_status", d, 0);
    csr_read(3'd0, d); chk("midrst_base", d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
